// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the EX/MEM/WB stage registers and the hazard unit.
// memwb_t uses the default field widths. The stage modules themselves are parametrised.
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_RD_W   = 5;
  localparam int PIPE_WB_W   = 2;
  localparam int PIPE_CNT_W  = 16;

  localparam int WB_REGWRITE_BIT = 1;
  localparam int WB_MEMTOREG_BIT = 0;

  typedef struct packed {
    logic [PIPE_WB_W-1:0]   wb;
    logic [PIPE_DATA_W-1:0] addr;
    logic [PIPE_DATA_W-1:0] data;
    logic [PIPE_RD_W-1:0]   rd;
  } memwb_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer: a payload register plus a valid flag.
// clear has priority over load, and load has priority over unload.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic         unload_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (clear_i) begin
      valid_o <= 1'b0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
    end else if (unload_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/memwb_stage.sv
// MEM->WB pipeline register with valid/ready handshake, flush and a saturating bubble counter.
// Define MEMWB_SKID_EN to add a one-entry skid buffer, which makes ready_o a registered signal.
module memwb_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int RD_W   = PIPE_RD_W,
  parameter int WB_W   = PIPE_WB_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [WB_W-1:0]   wb_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WB_W-1:0]   wb_o,
  output logic [DATA_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  localparam int PW = WB_W + 2*DATA_W + RD_W;

  logic             valid_q;
  logic [PW-1:0]    pay_q;
  logic [PW-1:0]    pay_in;
  logic [PW-1:0]    main_d;
  logic [WB_W-1:0]  wb_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             consume;
  logic             load_main;

  assign pay_in  = {wb_i, addr_i, data_i, rd_i};
  assign accept  = valid_i & ready_o;
  assign consume = valid_q & ready_i;

`ifdef MEMWB_SKID_EN
  logic          skid_valid;
  logic [PW-1:0] skid_data;
  logic          skid_load;
  logic          skid_unload;

  // An entry accepted while the main register is stalled waits in the skid buffer.
  assign ready_o     = !skid_valid;
  assign skid_load   = accept & valid_q & !ready_i;
  assign skid_unload = consume & skid_valid;
  assign load_main   = skid_unload | (accept & (!valid_q | ready_i));
  assign main_d      = skid_valid ? skid_data : pay_in;

  pipe_skid_buf #(.W(PW)) u_skid (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (flush_i),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .data_i   (pay_in),
    .data_o   (skid_data),
    .valid_o  (skid_valid)
  );
`else
  assign ready_o   = ready_i | !valid_q;
  assign load_main = accept & (!valid_q | ready_i);
  assign main_d    = pay_in;
`endif

  // The payload is left stale on flush or drain. wb_o gating keeps that safe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_main) begin
      valid_q <= 1'b1;
      pay_q   <= main_d;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!valid_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign {wb_q, addr_o, data_o, rd_o} = pay_q;
  assign valid_o      = valid_q;
  assign wb_o         = valid_q ? wb_q : '0;
  assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_memwb_stage.sv
// Testbench for memwb_stage. A queue-based model tracks held entries, ready and bubble cycles.
// The second instance uses CNT_W=4 so that counter saturation can be checked.
module tb_memwb_stage;

`ifdef MEMWB_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, flush_i, valid_i, ready_i;
  logic [1:0]  wb_i;
  logic [31:0] addr_i, data_i;
  logic [4:0]  rd_i;
  logic        ready_o, valid_o;
  logic [1:0]  wb_o;
  logic [31:0] addr_o, data_o;
  logic [4:0]  rd_o;
  logic [15:0] bubble_cnt_o;

  logic        rst4;
  logic        zero1 = 1'b0;
  logic [1:0]  zero2 = '0;
  logic [31:0] zero32 = '0;
  logic [4:0]  zero5 = '0;
  logic        ready4, valid4;
  logic [1:0]  wb4;
  logic [31:0] addr4, data4;
  logic [4:0]  rd4;
  logic [3:0]  cnt4;

  ent_t mq[$];
  int   mcnt;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  memwb_stage dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .wb_i(wb_i), .addr_i(addr_i), .data_i(data_i), .rd_i(rd_i),
    .valid_o(valid_o), .ready_i(ready_i), .wb_o(wb_o), .addr_o(addr_o),
    .data_o(data_o), .rd_o(rd_o), .bubble_cnt_o(bubble_cnt_o)
  );

  memwb_stage #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst4), .flush_i(zero1), .valid_i(zero1), .ready_o(ready4),
    .wb_i(zero2), .addr_i(zero32), .data_i(zero32), .rd_i(zero5),
    .valid_o(valid4), .ready_i(zero1), .wb_o(wb4), .addr_o(addr4),
    .data_o(data4), .rd_o(rd4), .bubble_cnt_o(cnt4)
  );

  function automatic bit m_ready();
    if (SKID) return mq.size() < 2;
    return ready_i || (mq.size() == 0);
  endfunction

  // Advance one clock edge and update the model from the inputs held across that edge.
  task automatic step();
    bit   rdy;
    ent_t e;
    rdy = m_ready();
    @(posedge clk);
    if (mq.size() == 0 && mcnt < 65535) mcnt++;
    if (flush_i) mq.delete();
    else begin
      if (mq.size() > 0 && ready_i) void'(mq.pop_front());
      if (valid_i && rdy) begin
        e = '{wb: wb_i, addr: addr_i, data: data_i, rd: rd_i};
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush_i = 0; valid_i = 0; ready_i = 0;
    wb_i = 0; addr_i = 0; data_i = 0; rd_i = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    mcnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    valid_i = 1; ready_i = 1; wb_i = 2'b11; addr_i = 32'h100; data_i = 32'hdead; rd_i = 5'd3;
    step(); step();
    n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL reset_pre_valid: got %0b want 1", valid_o); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({valid_o, wb_o, addr_o, data_o, rd_o, bubble_cnt_o} !== '0) begin
      n_err++;
      $display("FAIL reset_async_clear: valid=%0b wb=%0b addr=%h data=%h rd=%0d cnt=%0d want all 0",
               valid_o, wb_o, addr_o, data_o, rd_o, bubble_cnt_o);
    end
    @(posedge clk); #2;
    rst = 1'b0; valid_i = 0; ready_i = 0;
    mq.delete(); mcnt = 0;
    #1;
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b want 1", ready_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
  endtask

  task automatic test_streaming();
    logic [31:0] seq [3];
    seq[0] = 32'h10; seq[1] = 32'h14; seq[2] = 32'h18;
    do_reset();
    ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1; addr_i = seq[i]; data_i = $urandom; rd_i = 5'($urandom); wb_i = 2'b10;
      step();
      n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %0b want 1", i, valid_o); end
      n_cmp++; if (addr_o !== seq[i]) begin n_err++; $display("FAIL stream_addr[%0d]: got %h want %h", i, addr_o, seq[i]); end
      n_cmp++; if (bubble_cnt_o !== 16'd1) begin n_err++; $display("FAIL stream_cnt[%0d]: got %0d want 1", i, bubble_cnt_o); end
    end
    valid_i = 0;
  endtask

  task automatic test_backpressure();
    int items [3];
    int got[$];
    int idx;
    bit acc, exp_rdy;
    items[0] = 5; items[1] = 6; items[2] = 7;
    do_reset();
    valid_i = 1; rd_i = 5; ready_i = 0; addr_i = $urandom; data_i = $urandom; wb_i = 2'b10;
    #1; step();
    idx = 1;
    for (int c = 0; c < 3; c++) begin
      ready_i = 0; valid_i = 1; rd_i = 5'(items[idx]); addr_i = $urandom;
      #1;
      exp_rdy = SKID && (c == 0);
      n_cmp++; if (valid_o !== 1'b1 || rd_o !== 5'd5) begin n_err++; $display("FAIL bp_hold[%0d]: valid=%0b rd=%0d want 1/5", c, valid_o, rd_o); end
      n_cmp++; if (ready_o !== exp_rdy) begin n_err++; $display("FAIL bp_ready[%0d]: got %0b want %0b", c, ready_o, exp_rdy); end
      acc = valid_i && ready_o;
      step();
      if (acc) idx++;
    end
    ready_i = 1;
    for (int c = 0; c < 12 && got.size() < 3; c++) begin
      if (idx < 3) begin valid_i = 1; rd_i = 5'(items[idx]); end
      else valid_i = 0;
      #1;
      if (valid_o && ready_i) got.push_back(int'(rd_o));
      acc = valid_i && ready_o;
      step();
      if (acc) idx++;
    end
    valid_i = 0;
    n_cmp++; if (got.size() != 3) begin n_err++; $display("FAIL bp_count: got %0d entries want 3", got.size()); end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      n_cmp++; if (got[i] != items[i]) begin n_err++; $display("FAIL bp_order[%0d]: got %0d want %0d", i, got[i], items[i]); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    ready_i = 0; valid_i = 1; rd_i = 1; wb_i = 2'b01;
    #1; step();
    rd_i = 2;
    #1; step();
    flush_i = 1; valid_i = 1; wb_i = 2'b10; rd_i = 3;
    #1; step();
    flush_i = 0; valid_i = 0;
    #1;
    n_cmp++; if (valid_o !== 1'b0 || wb_o !== 2'b00) begin n_err++; $display("FAIL flush_out: valid=%0b wb=%0b want 0/00", valid_o, wb_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %0b want 1", ready_o); end
    ready_i = 1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL flush_drop[%0d]: valid=%0b rd=%0d want invalid", c, valid_o, rd_o); end
    end
    flush_i = 1; valid_i = 1; rd_i = 9; wb_i = 2'b11;
    #1;
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL flush_acc_ready: got %0b want 1", ready_o); end
    step();
    flush_i = 0; valid_i = 0;
    #1;
    n_cmp++; if (valid_o !== 1'b0 || wb_o !== 2'b00) begin n_err++; $display("FAIL flush_acc_drop: valid=%0b wb=%0b want 0/00", valid_o, wb_o); end
  endtask

  task automatic test_bubble_gating();
    int c0;
    do_reset();
    ready_i = 1;
    c0 = mcnt;
    for (int c = 0; c < 4; c++) begin
      valid_i = 0; wb_i = 2'b11; rd_i = 5'($urandom);
      step();
      n_cmp++; if (wb_o !== 2'b00 || valid_o !== 1'b0) begin n_err++; $display("FAIL bubble_wb[%0d]: wb=%0b valid=%0b want 00/0", c, wb_o, valid_o); end
    end
    n_cmp++; if (bubble_cnt_o !== 16'(c0 + 4)) begin n_err++; $display("FAIL bubble_cnt: got %0d want %0d", bubble_cnt_o, c0 + 4); end
  endtask

  task automatic test_saturation();
    int e;
    rst4 = 1;
    @(posedge clk); #1;
    rst4 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      e = (k < 15) ? k : 15;
      n_cmp++; if (cnt4 !== 4'(e)) begin n_err++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, cnt4, e); end
    end
  endtask

  task automatic test_random();
    ent_t h;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 2) != 0);
      flush_i = ($urandom_range(0, 15) == 0);
      wb_i = 2'($urandom); addr_i = $urandom; data_i = $urandom; rd_i = 5'($urandom);
      #1;
      n_cmp++; if (valid_o !== (mq.size() > 0)) begin n_err++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", c, valid_o, mq.size() > 0); end
      n_cmp++; if (ready_o !== m_ready()) begin n_err++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", c, ready_o, m_ready()); end
      n_cmp++; if (bubble_cnt_o !== mcnt[15:0]) begin n_err++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", c, bubble_cnt_o, mcnt); end
      if (mq.size() > 0) begin
        h = mq[0];
        n_cmp++;
        if ({wb_o, addr_o, data_o, rd_o} !== h) begin
          n_err++;
          $display("FAIL rnd_payload[%0d]: got wb=%0b addr=%h data=%h rd=%0d want wb=%0b addr=%h data=%h rd=%0d",
                   c, wb_o, addr_o, data_o, rd_o, h.wb, h.addr, h.data, h.rd);
        end
      end else begin
        n_cmp++; if (wb_o !== 2'b00) begin n_err++; $display("FAIL rnd_wbgate[%0d]: got %0b want 00", c, wb_o); end
      end
      step();
    end
    flush_i = 0; valid_i = 0;
  endtask

  initial begin
    rst = 1; rst4 = 1;
    flush_i = 0; valid_i = 0; ready_i = 0;
    wb_i = 0; addr_i = 0; data_i = 0; rd_i = 0;
    mcnt = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble_gating();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
